// File: rtl/io_pkg.sv
// Shared definitions for the memory-mapped I/O transmitter: register offsets,
// STATUS/CTRL bit positions and the transmit FSM encoding.
package io_pkg;

  localparam logic [1:0] IO_TXDATA = 2'd0;
  localparam logic [1:0] IO_STATUS = 2'd1;
  localparam logic [1:0] IO_CTRL   = 2'd2;

  localparam int ST_FULL    = 0;
  localparam int ST_EMPTY   = 1;
  localparam int ST_BUSY    = 2;
  localparam int ST_IRQ     = 3;
  localparam int ST_CNT_LSB = 4;
  localparam int ST_OVF     = 7;

  localparam int CTRL_IRQ_EN = 0;
  localparam int CTRL_TX_EN  = 1;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_START = 2'd1,
    S_DATA  = 2'd2,
    S_STOP  = 2'd3
  } tx_state_e;

endpackage

// File: rtl/io_uart_tx_byte_fifo.sv
// Small synchronous byte FIFO with combinational head output, so the consumer
// can take the head byte on the same edge it pops.
module byte_fifo #(
  parameter int DEPTH = 4,
  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1,
  localparam int CW = $clog2(DEPTH) + 1
) (
  input  logic          CLK,
  input  logic          R,
  input  logic          push,
  input  logic          pop,
  input  logic [7:0]    din,
  output logic [7:0]    dout,
  output logic          full,
  output logic          empty,
  output logic [CW-1:0] count
);

  logic [7:0]    mem_q [DEPTH];
  logic [AW-1:0] wr_ptr_q, wr_ptr_d;
  logic [AW-1:0] rd_ptr_q, rd_ptr_d;
  logic [CW-1:0] count_q, count_d;
  logic          wr_en;
  logic          rd_en;

  assign full  = (count_q == CW'(DEPTH));
  assign empty = (count_q == '0);
  assign count = count_q;
  assign dout  = mem_q[rd_ptr_q];

  // A push into a full FIFO is still accepted when the head leaves on the same edge.
  assign rd_en = pop & ~empty;
  assign wr_en = push & (~full | rd_en);

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (wr_en) begin
      wr_ptr_d = (wr_ptr_q == AW'(DEPTH - 1)) ? '0 : wr_ptr_q + AW'(1);
    end
    if (rd_en) begin
      rd_ptr_d = (rd_ptr_q == AW'(DEPTH - 1)) ? '0 : rd_ptr_q + AW'(1);
    end
    case ({wr_en, rd_en})
      2'b10:   count_d = count_q + CW'(1);
      2'b01:   count_d = count_q - CW'(1);
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge CLK) begin
    if (wr_en) begin
      mem_q[wr_ptr_q] <= din;
    end
  end

  always_ff @(posedge CLK or negedge R) begin
    if (!R) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

endmodule

// File: rtl/io_uart_tx.sv
// Memory-mapped 8N1 serial transmitter: 4-byte register window, transmit FIFO,
// baud counter, shift register and frame FSM.
module io_uart_tx
  import io_pkg::*;
#(
  parameter logic [15:0] BASE         = 16'hFF00,
  parameter logic [15:0] CLKS_PER_BIT = 16'd868,
  parameter int          FIFO_DEPTH   = 4
) (
  input  logic        CLK,
  input  logic        R,
  input  logic [15:0] Address,
  input  logic [7:0]  DataIn,
  input  logic        WE,
  output logic        SEL,
  output logic [7:0]  DataOut,
  output logic        TXD,
  output logic        IRQ
);

  localparam int          CW     = $clog2(FIFO_DEPTH) + 1;
  localparam logic [15:0] CPB_M1 = CLKS_PER_BIT - 16'd1;

  tx_state_e     state_q, state_d;
  logic [15:0]   baud_q, baud_d;
  logic [2:0]    bit_idx_q, bit_idx_d;
  logic [7:0]    shift_q, shift_d;
  logic          txd_q, txd_d;
  logic          irq_q, irq_d;
  logic          irq_pend_q, irq_pend_d;
  logic          ovf_q, ovf_d;
  logic          irq_en_q, irq_en_d;
  logic          tx_en_q, tx_en_d;

  logic          bus_wr;
  logic [1:0]    offset;
  logic          fifo_push;
  logic          fifo_pop;
  logic [7:0]    fifo_dout;
  logic          fifo_full;
  logic          fifo_empty;
  logic [CW-1:0] fifo_count;
  logic [2:0]    count3;
  logic          bit_end;
  logic          irq_set;
  logic          ovf_set;

  assign SEL       = (Address[15:2] == BASE[15:2]);
  assign offset    = Address[1:0];
  assign bus_wr    = WE & SEL;
  assign fifo_push = bus_wr & (offset == IO_TXDATA);
  assign ovf_set   = fifo_push & fifo_full & ~fifo_pop;
  assign count3    = 3'(fifo_count);
  assign bit_end   = (baud_q == 16'd0);
  assign TXD       = txd_q;
  assign IRQ       = irq_q;

  byte_fifo #(.DEPTH(FIFO_DEPTH)) u_fifo (
    .CLK   (CLK),
    .R     (R),
    .push  (fifo_push),
    .pop   (fifo_pop),
    .din   (DataIn),
    .dout  (fifo_dout),
    .full  (fifo_full),
    .empty (fifo_empty),
    .count (fifo_count)
  );

  always_comb begin
    state_d   = state_q;
    baud_d    = baud_q;
    bit_idx_d = bit_idx_q;
    shift_d   = shift_q;
    txd_d     = txd_q;
    fifo_pop  = 1'b0;
    irq_set   = 1'b0;
    if (state_q != S_IDLE && !bit_end) begin
      baud_d = baud_q - 16'd1;
    end
    case (state_q)
      S_IDLE: begin
        if (tx_en_q && !fifo_empty) begin
          fifo_pop = 1'b1;
          shift_d  = fifo_dout;
          baud_d   = CPB_M1;
          txd_d    = 1'b0;
          state_d  = S_START;
        end
      end
      S_START: begin
        if (bit_end) begin
          state_d   = S_DATA;
          txd_d     = shift_q[0];
          bit_idx_d = 3'd0;
          baud_d    = CPB_M1;
        end
      end
      S_DATA: begin
        if (bit_end) begin
          baud_d = CPB_M1;
          if (bit_idx_q == 3'd7) begin
            state_d = S_STOP;
            txd_d   = 1'b1;
          end else begin
            // LSB-first: the next line bit is the one that becomes shift[0].
            shift_d   = {1'b0, shift_q[7:1]};
            txd_d     = shift_q[1];
            bit_idx_d = bit_idx_q + 3'd1;
          end
        end
      end
      S_STOP: begin
        if (bit_end) begin
          baud_d = CPB_M1;
          if (tx_en_q && !fifo_empty) begin
            fifo_pop = 1'b1;
            shift_d  = fifo_dout;
            txd_d    = 1'b0;
            state_d  = S_START;
          end else begin
            txd_d   = 1'b1;
            irq_set = 1'b1;
            state_d = S_IDLE;
          end
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_comb begin
    irq_en_d   = irq_en_q;
    tx_en_d    = tx_en_q;
    irq_pend_d = irq_pend_q;
    ovf_d      = ovf_q;
    if (bus_wr && offset == IO_CTRL) begin
      irq_en_d = DataIn[CTRL_IRQ_EN];
      tx_en_d  = DataIn[CTRL_TX_EN];
    end
    if (bus_wr && offset == IO_STATUS) begin
      if (DataIn[ST_IRQ]) irq_pend_d = 1'b0;
      if (DataIn[ST_OVF]) ovf_d      = 1'b0;
    end
    // Hardware events override a software clear landing on the same edge.
    if (irq_set) irq_pend_d = 1'b1;
    if (ovf_set) ovf_d      = 1'b1;
    irq_d = irq_pend_d & irq_en_d;
  end

  always_comb begin
    DataOut = 8'h00;
    if (SEL) begin
      case (offset)
        IO_STATUS: begin
          DataOut[ST_FULL]             = fifo_full;
          DataOut[ST_EMPTY]            = fifo_empty;
          DataOut[ST_BUSY]             = (state_q != S_IDLE);
          DataOut[ST_IRQ]              = irq_pend_q;
          DataOut[ST_CNT_LSB +: 3]     = count3;
          DataOut[ST_OVF]              = ovf_q;
        end
        IO_CTRL: begin
          DataOut[CTRL_IRQ_EN] = irq_en_q;
          DataOut[CTRL_TX_EN]  = tx_en_q;
        end
        default: DataOut = 8'h00;
      endcase
    end
  end

  always_ff @(posedge CLK or negedge R) begin
    if (!R) begin
      state_q    <= S_IDLE;
      baud_q     <= 16'd0;
      bit_idx_q  <= 3'd0;
      shift_q    <= 8'h00;
      txd_q      <= 1'b1;
      irq_q      <= 1'b0;
      irq_pend_q <= 1'b0;
      ovf_q      <= 1'b0;
      irq_en_q   <= 1'b0;
      tx_en_q    <= 1'b1;
    end else begin
      state_q    <= state_d;
      baud_q     <= baud_d;
      bit_idx_q  <= bit_idx_d;
      shift_q    <= shift_d;
      txd_q      <= txd_d;
      irq_q      <= irq_d;
      irq_pend_q <= irq_pend_d;
      ovf_q      <= ovf_d;
      irq_en_q   <= irq_en_d;
      tx_en_q    <= tx_en_d;
    end
  end

endmodule
